tile_loader: RTL
================

// Module: tile_loader
// PURPOSE
// - Upstream feeder for the convolution chip: takes one host word stream (valid/ready), fills kernel mem, input mem and overlap cache.
// - Drives the chip's a_input (write address), b_input (data), int_mem_we, overlap_cache_we and b_zero; pulses data_ready when a tile is resident.
// - One load = optional KERNEL phase, INPUT phase with right-edge zero fill, optional OVERLAP phase.
// PARAMETERS
// - IO_DATA_WIDTH    16   word width of stream and b_input
// - TILE_W           64   tile columns (x field 6b)
// - TILE_H           128  tile rows (y field 7b)
// - TILE_CH          2    input channels per tile (inch field 1b)
// - KERNEL_SIZE      3    kernel side; ky/kx fields 2b, code 3 never generated
// - KOUT_CH          16   output channels per kernel load (outch field 4b)
// PORTS
// - clk              in   1     clock, rising edge
// - arst_in          in   1     asynchronous reset, active-high
// - start            in   1     load request, sampled only in IDLE
// - load_kernel      in   1     sampled with start: run KERNEL phase
// - load_overlap     in   1     sampled with start: run OVERLAP phase
// - valid_cols       in   7     sampled with start: real columns 1..64; x>=valid_cols zero-filled
// - s_data           in   16    host stream data
// - s_valid          in   1     host stream valid
// - s_ready          out  1     loader accepts s_data this cycle
// - a_input          out  16    write address to chip
// - b_input          out  16    write data to chip
// - int_mem_we       out  1     write strobe, kernel/input mem (bit15 selects)
// - overlap_cache_we out  1     write strobe, overlap cache
// - b_zero           out  1     force-zero data for input mem write
// - data_ready       out  1     one-cycle pulse: tile loaded
// - busy             out  1     high whenever state != IDLE
// BEHAVIOUR
// - All outputs registered; reset value 0 for every output, state IDLE.
// - States: IDLE -> KERNEL (if load_kernel) -> INPUT -> OVERLAP (if load_overlap) -> DONE -> IDLE.
// - start while busy ignored; start with valid_cols==0 or >64 clamps to 64.
// - Transfer = s_valid && s_ready. Write appears on outputs the cycle after transfer (latency 1); one write per cycle max.
// - s_ready = 1 in KERNEL, OVERLAP, and INPUT when x<valid_cols; 0 in IDLE, DONE and during zero fill.
// - KERNEL: 288 words; order outch fastest, then kx, ky, inch; a_input={1,6'b0,inch,ky,kx,outch}; int_mem_we=1.
// - INPUT: 16384 slots; x fastest, then y, inch; a_input={2'b0,inch,y,x}; x<valid_cols consumes a word;
//   x>=valid_cols: no consume, write next cycle with b_zero=1, b_input=0, int_mem_we=1 (one slot per cycle).
// - OVERLAP: 256 words; y fastest, then inch; a_input={8'b0,inch,y}; overlap_cache_we=1, int_mem_we=0.
// - Counters wrap to 0 on phase exit; last slot of a phase moves state the same cycle its write is issued.
// - DONE: data_ready=1 for exactly one cycle, then IDLE; busy falls with data_ready.
// - s_valid low stalls counters; no write strobe that cycle; no bubble inserted when s_valid held high.
// - arst_in mid-load: immediate IDLE, strobes 0; partially written memories are undefined, host reloads fully.
// - Strobes int_mem_we and overlap_cache_we never high together; b_zero only with int_mem_we and a_input[15]=0.
// STRUCTURE
// - tile_loader_pkg: phase_t enum {IDLE,KERNEL,INPUT,OVERLAP,DONE}; field widths X_W=6,Y_W=7,CH_W=1,K_W=2,OC_W=4;
//   KERNEL_SEL_BIT=15; phase lengths KERNEL_WORDS=288, INPUT_WORDS=16384, OVERLAP_WORDS=256.
// - Sub-module tile_addr_gen: nested wrap counters (inc, clear, per-field maxima) with last flag; one instance, fields remapped per phase.
// - Top: FSM, stream handshake, output registers.
// TESTING
// - Reset mid-INPUT (after 100 words) -> next cycle all outputs 0, busy=0; new start loads cleanly from x=y=0.
// - start, load_kernel=1, s_valid always 1 -> 288 writes, first a_input=0x8000, 5th word 0x8004, word 17 0x8010, last 0x8000|{1,2,2,15}=0x81AF.
// - valid_cols=60, load_overlap=0 -> per row 60 consumed words then 4 b_zero writes at x=60..63; total 15360 words consumed.
// - load_overlap=1 -> 256 overlap_cache_we writes a_input 0..255, int_mem_we=0 throughout, then data_ready single pulse.
// - s_valid toggling 1/0 random 50% -> write count, order and addresses identical to continuous case; no strobe on idle cycles.
// - start pulsed while busy and at DONE -> ignored, exactly one data_ready per accepted start.

Source files
------------

// File: rtl/tile_loader_pkg.sv
// Shared types, field widths and phase sizes for the tile loader.
// The loader fills kernel memory, input memory and the overlap cache from one host word stream.
package tile_loader_pkg;

   localparam int unsigned IO_DATA_WIDTH = 16;
   localparam int unsigned ADDR_W        = 16;
   localparam int unsigned TILE_W        = 64;
   localparam int unsigned TILE_H        = 128;
   localparam int unsigned TILE_CH       = 2;
   localparam int unsigned KERNEL_SIZE   = 3;
   localparam int unsigned KOUT_CH       = 16;

   localparam int unsigned X_W  = 6;
   localparam int unsigned Y_W  = 7;
   localparam int unsigned CH_W = 1;
   localparam int unsigned K_W  = 2;
   localparam int unsigned OC_W = 4;

   localparam int unsigned COLS_W   = 7;
   localparam int unsigned CNT_W    = 7;
   localparam int unsigned N_FIELDS = 4;

   localparam int unsigned KERNEL_SEL_BIT = 15;

   localparam int unsigned KERNEL_WORDS  = 288;
   localparam int unsigned INPUT_WORDS   = 16384;
   localparam int unsigned OVERLAP_WORDS = 256;

   typedef enum logic [2:0] {
      IDLE,
      KERNEL,
      INPUT,
      OVERLAP,
      DONE
   } phase_t;

   // Field 0 is the fastest-moving counter.
   typedef logic [N_FIELDS-1:0][CNT_W-1:0] fields_t;

   typedef struct packed {
      logic [ADDR_W-1:0]        addr;
      logic [IO_DATA_WIDTH-1:0] data;
      logic                     int_we;
      logic                     ovl_we;
      logic                     zero;
   } wr_t;

   // Zero or out-of-range column counts mean a full-width tile.
   function automatic logic [COLS_W-1:0] clamp_cols(input logic [COLS_W-1:0] c);
      if (c == '0 || c > COLS_W'(TILE_W)) return COLS_W'(TILE_W);
      return c;
   endfunction

endpackage

// File: rtl/tile_addr_gen.sv
// Nested wrap counters: field 0 fastest; each field rolls over at its own maximum.
// last flags the final slot; incrementing on the final slot returns every field to zero.
module tile_addr_gen
   import tile_loader_pkg::*;
(
   input  logic             clk,
   input  logic             arst_in,
   input  logic             inc,
   input  logic             clear,
   input  fields_t          max_val,
   output fields_t          cnt,
   output logic [CNT_W-1:0] nxt0,
   output logic             last
);

   fields_t nxt;
   logic    carry;

   always_comb begin
      last = 1'b1;
      for (int i = 0; i < int'(N_FIELDS); i++) begin
         if (cnt[i] != max_val[i]) last = 1'b0;
      end
   end

   // Ripple carry from the fastest field upward.
   always_comb begin
      nxt   = cnt;
      carry = inc;
      if (clear) begin
         nxt = '0;
      end else begin
         for (int i = 0; i < int'(N_FIELDS); i++) begin
            if (carry) begin
               if (cnt[i] == max_val[i]) begin
                  nxt[i] = '0;
               end else begin
                  nxt[i] = cnt[i] + CNT_W'(1);
                  carry  = 1'b0;
               end
            end
         end
      end
   end

   assign nxt0 = nxt[0];

   always_ff @(posedge clk or posedge arst_in) begin
      if (arst_in) cnt <= '0;
      else         cnt <= nxt;
   end

endmodule

// File: rtl/tile_loader.sv
// Streams one tile load (kernel, input with right-edge zero fill, overlap) into the chip memories.
// Every write leaves the output registers one cycle after the slot it belongs to is taken.
module tile_loader
   import tile_loader_pkg::*;
(
   input  logic                     clk,
   input  logic                     arst_in,
   input  logic                     start,
   input  logic                     load_kernel,
   input  logic                     load_overlap,
   input  logic [COLS_W-1:0]        valid_cols,
   input  logic [IO_DATA_WIDTH-1:0] s_data,
   input  logic                     s_valid,
   output logic                     s_ready,
   output logic [ADDR_W-1:0]        a_input,
   output logic [IO_DATA_WIDTH-1:0] b_input,
   output logic                     int_mem_we,
   output logic                     overlap_cache_we,
   output logic                     b_zero,
   output logic                     data_ready,
   output logic                     busy
);

   phase_t            state, state_nxt;
   logic              lo_q;
   logic [COLS_W-1:0] cols_q, cols_d;

   fields_t           gen_max, gen_cnt;
   logic [CNT_W-1:0]  gen_nxt0;
   logic              gen_last, gen_clear;

   logic              fill, adv;
   wr_t               wr_d, wr_q;
   logic              s_ready_d, busy_d, data_ready_d;

   // Field views of the shared counter, one set per phase.
   logic [OC_W-1:0] k_oc;
   logic [K_W-1:0]  k_x, k_y;
   logic [CH_W-1:0] k_ch, i_ch, o_ch;
   logic [X_W-1:0]  i_x;
   logic [Y_W-1:0]  i_y, o_y;
   logic            unused_bits;

   assign k_oc = gen_cnt[0][OC_W-1:0];
   assign k_x  = gen_cnt[1][K_W-1:0];
   assign k_y  = gen_cnt[2][K_W-1:0];
   assign k_ch = gen_cnt[3][CH_W-1:0];
   assign i_x  = gen_cnt[0][X_W-1:0];
   assign i_y  = gen_cnt[1][Y_W-1:0];
   assign i_ch = gen_cnt[2][CH_W-1:0];
   assign o_y  = gen_cnt[0][Y_W-1:0];
   assign o_ch = gen_cnt[1][CH_W-1:0];
   assign unused_bits = &{1'b0, gen_cnt[3][CNT_W-1:CH_W], gen_cnt[2][CNT_W-1:K_W]};

   always_comb begin
      gen_max = '0;
      case (state)
         KERNEL:  gen_max = {CNT_W'(TILE_CH - 1), CNT_W'(KERNEL_SIZE - 1),
                             CNT_W'(KERNEL_SIZE - 1), CNT_W'(KOUT_CH - 1)};
         INPUT:   gen_max = {CNT_W'(0), CNT_W'(TILE_CH - 1),
                             CNT_W'(TILE_H - 1), CNT_W'(TILE_W - 1)};
         OVERLAP: gen_max = {CNT_W'(0), CNT_W'(0),
                             CNT_W'(TILE_CH - 1), CNT_W'(TILE_H - 1)};
         default: gen_max = '0;
      endcase
   end

   assign gen_clear = (state == IDLE);

   // Zero-fill slots advance every cycle without touching the stream.
   assign fill = (state == INPUT) && ({1'b0, i_x} >= cols_q);

   always_comb begin
      adv = 1'b0;
      case (state)
         KERNEL, OVERLAP: adv = s_valid && s_ready;
         INPUT:           adv = fill || (s_valid && s_ready);
         default:         adv = 1'b0;
      endcase
   end

   tile_addr_gen u_addr_gen (
      .clk     (clk),
      .arst_in (arst_in),
      .inc     (adv),
      .clear   (gen_clear),
      .max_val (gen_max),
      .cnt     (gen_cnt),
      .nxt0    (gen_nxt0),
      .last    (gen_last)
   );

   always_ff @(posedge clk or posedge arst_in) begin
      if (arst_in) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = load_kernel ? KERNEL : INPUT;
         KERNEL:  if (adv && gen_last) state_nxt = INPUT;
         INPUT:   if (adv && gen_last) state_nxt = lo_q ? OVERLAP : DONE;
         OVERLAP: if (adv && gen_last) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign cols_d = (state == IDLE && start) ? clamp_cols(valid_cols) : cols_q;

   // s_ready is precomputed for the coming cycle from the next state and column.
   always_comb begin
      wr_d         = '0;
      s_ready_d    = 1'b0;
      busy_d       = (state_nxt != IDLE);
      data_ready_d = (state_nxt == DONE);
      if (adv) begin
         case (state)
            KERNEL: begin
               wr_d.addr                 = ADDR_W'({k_ch, k_y, k_x, k_oc});
               wr_d.addr[KERNEL_SEL_BIT] = 1'b1;
               wr_d.data                 = s_data;
               wr_d.int_we               = 1'b1;
            end
            INPUT: begin
               wr_d.addr   = ADDR_W'({i_ch, i_y, i_x});
               wr_d.data   = fill ? '0 : s_data;
               wr_d.int_we = 1'b1;
               wr_d.zero   = fill;
            end
            OVERLAP: begin
               wr_d.addr   = ADDR_W'({o_ch, o_y});
               wr_d.data   = s_data;
               wr_d.ovl_we = 1'b1;
            end
            default: wr_d = '0;
         endcase
      end
      case (state_nxt)
         KERNEL, OVERLAP: s_ready_d = 1'b1;
         INPUT:           s_ready_d = (gen_nxt0 < cols_d);
         default:         s_ready_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge arst_in) begin
      if (arst_in) begin
         wr_q       <= '0;
         s_ready    <= 1'b0;
         busy       <= 1'b0;
         data_ready <= 1'b0;
         lo_q       <= 1'b0;
         cols_q     <= COLS_W'(TILE_W);
      end else begin
         wr_q       <= wr_d;
         s_ready    <= s_ready_d;
         busy       <= busy_d;
         data_ready <= data_ready_d;
         cols_q     <= cols_d;
         if (state == IDLE && start) lo_q <= load_overlap;
      end
   end

   assign a_input          = wr_q.addr;
   assign b_input          = wr_q.data;
   assign int_mem_we       = wr_q.int_we;
   assign overlap_cache_we = wr_q.ovl_we;
   assign b_zero           = wr_q.zero;

endmodule
